// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if : decoder/stage state in, stall/flush/forward/halt controls out.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_if;
  logic [4:0] D_RS1;
  logic [4:0] D_RS2;
  logic       D_useRS1;
  logic       D_useRS2;
  logic       D_valid;
  logic       D_exception;
  logic [4:0] E_RS1;
  logic [4:0] E_RS2;
  logic [4:0] E_RD;
  logic       E_RegWrite;
  logic       E_MemToReg;
  logic       E_redirect;
  logic [4:0] M_RD;
  logic [4:0] W_RD;
  logic       M_RegWrite;
  logic       W_RegWrite;
  logic       M_memReq;
  logic       dmem_ready;
  logic       stall_F;
  logic       stall_D;
  logic       stall_E;
  logic       stall_M;
  logic       flush_D;
  logic       flush_E;
  logic       flush_W;
  logic [1:0] fwdA;
  logic [1:0] fwdB;
  logic       halted;

  modport master (
    output D_RS1, D_RS2, D_useRS1, D_useRS2, D_valid, D_exception,
    output E_RS1, E_RS2, E_RD, E_RegWrite, E_MemToReg, E_redirect,
    output M_RD, W_RD, M_RegWrite, W_RegWrite, M_memReq, dmem_ready,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    input  fwdA, fwdB, halted
  );

  modport slave (
    input  D_RS1, D_RS2, D_useRS1, D_useRS2, D_valid, D_exception,
    input  E_RS1, E_RS2, E_RD, E_RegWrite, E_MemToReg, E_redirect,
    input  M_RD, W_RD, M_RegWrite, W_RegWrite, M_memReq, dmem_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    output fwdA, fwdB, halted
  );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller : 5-stage RV32I stall/flush/forwarding/halt control.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      cnt_stall_o,
  output logic [CNT_W-1:0]      cnt_flush_o,
`endif
  hazard_if.slave               hz
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       halted_q, halted_d;

  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_w;
  logic w_lu, w_dmem_stall, w_mem_hold;
  logic [1:0] w_fwd_a, w_fwd_b;

  // M result is younger than W, so it takes priority.
  always_comb begin
    w_fwd_a = 2'b00;
    if (hz.M_RegWrite && hz.M_RD != 5'd0 && hz.M_RD == hz.E_RS1)      w_fwd_a = 2'b10;
    else if (hz.W_RegWrite && hz.W_RD != 5'd0 && hz.W_RD == hz.E_RS1) w_fwd_a = 2'b01;
    w_fwd_b = 2'b00;
    if (hz.M_RegWrite && hz.M_RD != 5'd0 && hz.M_RD == hz.E_RS2)      w_fwd_b = 2'b10;
    else if (hz.W_RegWrite && hz.W_RD != 5'd0 && hz.W_RD == hz.E_RS2) w_fwd_b = 2'b01;
  end

  assign w_lu = hz.E_MemToReg && (hz.E_RD != 5'd0) && hz.D_valid &&
                ((hz.D_useRS1 && hz.E_RD == hz.D_RS1) ||
                 (hz.D_useRS2 && hz.E_RD == hz.D_RS2));

  assign w_dmem_stall = hz.M_memReq && !hz.dmem_ready;
  // Once waiting, the pending request is held by the stall itself; only ready releases it.
  assign w_mem_hold   = (state_q == S_MEM_WAIT) ? !hz.dmem_ready : w_dmem_stall;

  always_comb begin
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_stall_m   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_flush_w   = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (w_mem_hold) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_stall_m = 1'b1;
          w_flush_w = 1'b1;
          state_d   = S_MEM_WAIT;
        end else if (hz.E_redirect) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
          state_d   = S_RUN;
        end else if (hz.D_exception && hz.D_valid) begin
          w_stall_f   = 1'b1;
          w_flush_d   = 1'b1;
          drain_cnt_d = 2'(DRAIN_CYCLES - 1);
          state_d     = S_DRAIN;
        end else if (w_lu) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
          state_d   = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        w_stall_f = 1'b1;
        w_flush_d = 1'b1;
        if (w_dmem_stall) begin
          w_stall_e = 1'b1;
          w_stall_m = 1'b1;
          w_flush_w = 1'b1;
        end else if (drain_cnt_q == 2'd0) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      default: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
        halted_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  // Reset forces every control quiet immediately, whatever the inputs are doing.
  assign hz.stall_F = rst_n & w_stall_f;
  assign hz.stall_D = rst_n & w_stall_d;
  assign hz.stall_E = rst_n & w_stall_e;
  assign hz.stall_M = rst_n & w_stall_m;
  assign hz.flush_D = rst_n & w_flush_d;
  assign hz.flush_E = rst_n & w_flush_e;
  assign hz.flush_W = rst_n & w_flush_w;
  assign hz.fwdA    = rst_n ? w_fwd_a : 2'b00;
  assign hz.fwdB    = rst_n ? w_fwd_b : 2'b00;
  assign hz.halted  = halted_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q;
  logic             w_cnt_window;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign w_cnt_window = (state_q == S_RUN) || (state_q == S_MEM_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (w_stall_f && w_cnt_window && !(&cnt_stall_q)) cnt_stall_q <= cnt_stall_q + ONE;
      if (w_flush_e && w_cnt_window && !(&cnt_flush_q)) cnt_flush_q <= cnt_flush_q + ONE;
    end
  end

  assign cnt_stall_o = cnt_stall_q;
  assign cnt_flush_o = cnt_flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller : directed vectors with hand-computed expected controls.
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_controller;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  hazard_if hz();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_stall, cnt_flush;
`endif

  hazard_controller #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef HAZARD_PERF_CNT_EN
    .cnt_stall_o (cnt_stall),
    .cnt_flush_o (cnt_flush),
`endif
    .hz          (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected order {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M,
              hz.flush_D, hz.flush_E, hz.flush_W}, {25'd0, exp});
  endtask

  task automatic clear_inputs();
    hz.D_RS1 = 5'd0; hz.D_RS2 = 5'd0; hz.D_useRS1 = 1'b0; hz.D_useRS2 = 1'b0;
    hz.D_valid = 1'b0; hz.D_exception = 1'b0;
    hz.E_RS1 = 5'd0; hz.E_RS2 = 5'd0; hz.E_RD = 5'd0;
    hz.E_RegWrite = 1'b0; hz.E_MemToReg = 1'b0; hz.E_redirect = 1'b0;
    hz.M_RD = 5'd0; hz.W_RD = 5'd0; hz.M_RegWrite = 1'b0; hz.W_RegWrite = 1'b0;
    hz.M_memReq = 1'b0; hz.dmem_ready = 1'b0;
  endtask

  task automatic set_lu();
    hz.E_MemToReg = 1'b1; hz.E_RegWrite = 1'b1; hz.E_RD = 5'd3;
    hz.D_valid = 1'b1; hz.D_useRS1 = 1'b1; hz.D_RS1 = 5'd3;
  endtask

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk_ctl("reset_ctl", 7'b0000000);
    chk("reset_fwd", {28'd0, hz.fwdA, hz.fwdB}, 32'd0);
    chk("reset_halted", {31'd0, hz.halted}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    settle();
    chk("reset_cnt_stall", cnt_stall, 32'd0);
    chk("reset_cnt_flush", cnt_flush, 32'd0);
    next_cycle();
`endif

    // Forwarding
    hz.E_RegWrite = 1'b1; hz.E_RD = 5'd5;
    hz.M_RegWrite = 1'b1; hz.M_RD = 5'd5; hz.E_RS1 = 5'd5;
    settle();
    chk("fwdA_from_M", {30'd0, hz.fwdA}, 32'd2);
    chk_ctl("fwd_no_stall", 7'b0000000);
    next_cycle();
    hz.W_RegWrite = 1'b1; hz.W_RD = 5'd5;
    settle();
    chk("fwdA_M_wins", {30'd0, hz.fwdA}, 32'd2);
    next_cycle();
    hz.M_RegWrite = 1'b0;
    settle();
    chk("fwdA_from_W", {30'd0, hz.fwdA}, 32'd1);
    next_cycle();
    hz.M_RegWrite = 1'b1; hz.M_RD = 5'd5; hz.W_RD = 5'd7; hz.E_RS2 = 5'd7;
    settle();
    chk("fwd_A10_B01", {28'd0, hz.fwdA, hz.fwdB}, 32'b1001);
    next_cycle();
    hz.M_RD = 5'd0; hz.W_RD = 5'd0; hz.E_RS1 = 5'd0; hz.E_RS2 = 5'd0;
    settle();
    chk("fwd_x0", {28'd0, hz.fwdA, hz.fwdB}, 32'd0);
    next_cycle();
    clear_inputs();

    // Load-use
    set_lu();
    settle();
    chk_ctl("lu_rs1", 7'b1100010);
    next_cycle();
    hz.E_MemToReg = 1'b0;
    settle();
    chk_ctl("lu_bubble_gone", 7'b0000000);
    next_cycle();
    set_lu();
    hz.D_useRS1 = 1'b0;
    settle();
    chk_ctl("lu_rs1_unused", 7'b0000000);
    next_cycle();
    hz.D_useRS2 = 1'b1; hz.D_RS2 = 5'd3; hz.D_RS1 = 5'd9;
    settle();
    chk_ctl("lu_rs2", 7'b1100010);
    next_cycle();
    hz.E_RD = 5'd0; hz.D_RS2 = 5'd0;
    settle();
    chk_ctl("lu_x0", 7'b0000000);
    next_cycle();
    set_lu();
    hz.D_valid = 1'b0;
    settle();
    chk_ctl("lu_invalid_D", 7'b0000000);
    next_cycle();
    clear_inputs();

    // Data-memory wait: three stalled cycles, lu frozen meanwhile
    hz.M_memReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) set_lu();
      settle();
      chk_ctl($sformatf("memwait_%0d", i), 7'b1111001);
      next_cycle();
    end
    hz.dmem_ready = 1'b1;
    settle();
    chk_ctl("memwait_release_lu", 7'b1100010);
    next_cycle();
    clear_inputs();
    settle();
    chk_ctl("memwait_back_run", 7'b0000000);
    next_cycle();

    // Redirect beats exception and load-use
    set_lu();
    hz.D_exception = 1'b1; hz.E_redirect = 1'b1;
    settle();
    chk_ctl("redirect_prio", 7'b0000110);
    next_cycle();
    clear_inputs();
    settle();
    chk_ctl("redirect_stay_run", 7'b0000000);
    next_cycle();

    // Exception drain, with a dmem stall holding the counter and a redirect ignored
    hz.D_exception = 1'b1; hz.D_valid = 1'b1;
    settle();
    chk_ctl("exc_detect", 7'b1000100);
    next_cycle();
    clear_inputs();
    settle();
    chk_ctl("drain_1", 7'b1000100);
    chk("drain_1_halted", {31'd0, hz.halted}, 32'd0);
    next_cycle();
    hz.M_memReq = 1'b1;
    settle();
    chk_ctl("drain_dmem_stall", 7'b1011101);
    next_cycle();
    clear_inputs();
    hz.E_redirect = 1'b1;
    settle();
    chk_ctl("drain_2_redirect", 7'b1000100);
    next_cycle();
    clear_inputs();
    settle();
    chk_ctl("drain_3", 7'b1000100);
    chk("drain_3_halted", {31'd0, hz.halted}, 32'd0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_ctl($sformatf("halt_ctl_%0d", i), 7'b1111001);
      chk($sformatf("halt_flag_%0d", i), {31'd0, hz.halted}, 32'd1);
      next_cycle();
    end

    // Async reset out of HALT, then out of MEM_WAIT
    rst_n = 1'b0;
    #1;
    chk("rst_from_halt", {31'd0, hz.halted}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    hz.M_memReq = 1'b1;
    next_cycle();
    settle();
    chk_ctl("pre_rst_memwait", 7'b1111001);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk_ctl("rst_in_memwait", 7'b0000000);
    next_cycle();
    rst_n = 1'b1;
    hz.M_memReq = 1'b0;
    settle();
    chk_ctl("after_rst_run", 7'b0000000);
`ifdef HAZARD_PERF_CNT_EN
    chk("after_rst_cnt_stall", cnt_stall, 32'd0);
    chk("after_rst_cnt_flush", cnt_flush, 32'd0);
`endif
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
